// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared encodings for the multi-cycle RV32I control unit:
//               FSM states, opcodes and datapath select/op encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    ALU_WB    = 4'd4,
    MEM_ADR   = 4'd5,
    MEM_READ  = 4'd6,
    MEM_WB    = 4'd7,
    MEM_WRITE = 4'd8,
    BRANCH    = 4'd9,
    JAL_LINK  = 4'd10,
    JAL_JUMP  = 4'd11,
    JALR_LINK = 4'd12,
    JALR_JUMP = 4'd13,
    LUI       = 4'd14,
    HALT      = 4'd15
  } state_t;

  localparam logic [6:0] c_OPC_R      = 7'b0110011;
  localparam logic [6:0] c_OPC_I      = 7'b0010011;
  localparam logic [6:0] c_OPC_LW     = 7'b0000011;
  localparam logic [6:0] c_OPC_SW     = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;

  localparam logic [2:0] c_ALU_ADD  = 3'b000;
  localparam logic [2:0] c_ALU_SUB  = 3'b001;
  localparam logic [2:0] c_ALU_AND  = 3'b010;
  localparam logic [2:0] c_ALU_OR   = 3'b011;
  localparam logic [2:0] c_ALU_XOR  = 3'b100;
  localparam logic [2:0] c_ALU_SLT  = 3'b101;
  localparam logic [2:0] c_ALU_SLTU = 3'b110;

  localparam logic [2:0] c_IMM_I = 3'b000;
  localparam logic [2:0] c_IMM_S = 3'b001;
  localparam logic [2:0] c_IMM_B = 3'b010;
  localparam logic [2:0] c_IMM_J = 3'b011;
  localparam logic [2:0] c_IMM_U = 3'b100;

  localparam logic [1:0] c_SRCA_PC    = 2'b00;
  localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
  localparam logic [1:0] c_SRCA_REG   = 2'b10;

  localparam logic [1:0] c_SRCB_REG  = 2'b00;
  localparam logic [1:0] c_SRCB_IMM  = 2'b01;
  localparam logic [1:0] c_SRCB_FOUR = 2'b10;

  localparam logic [2:0] c_RES_ALUOUT = 3'b000;
  localparam logic [2:0] c_RES_ALU    = 3'b001;
  localparam logic [2:0] c_RES_MDR    = 3'b010;
  localparam logic [2:0] c_RES_IMM    = 3'b011;
  localparam logic [2:0] c_RES_PC     = 3'b100;

  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module      : alu_decoder
// Description : Combinational ALU operation decode from ALU_op and funct bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic       i_opc_b5,
  input  logic [2:0] i_func3,
  input  logic       i_func7_b5,
  output logic [2:0] o_alu_cntr
);

  always_comb begin
    o_alu_cntr = c_ALU_ADD;
    case (i_alu_op)
      c_ALUOP_SUB: o_alu_cntr = c_ALU_SUB;
      c_ALUOP_FUNCT: begin
        case (i_func3)
          // opc[5] separates R-type from I-type, which has no subi
          3'b000:  o_alu_cntr = (i_opc_b5 && i_func7_b5) ? c_ALU_SUB : c_ALU_ADD;
          3'b111:  o_alu_cntr = c_ALU_AND;
          3'b110:  o_alu_cntr = c_ALU_OR;
          3'b100:  o_alu_cntr = c_ALU_XOR;
          3'b010:  o_alu_cntr = c_ALU_SLT;
          3'b011:  o_alu_cntr = c_ALU_SLTU;
          default: o_alu_cntr = c_ALU_ADD;
        endcase
      end
      default: o_alu_cntr = c_ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Multi-cycle RV32I control FSM driving datapath enables/selects.
//               Optional macro ILLEGAL_TRAP_EN: unknown opcodes halt the FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opc,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       pos,
  output logic       Reg_write,
  output logic [2:0] Imm_src,
  output logic [1:0] ALU_srcA,
  output logic [1:0] ALU_srcB,
  output logic [2:0] ALU_cntr,
  output logic [2:0] Result_src,
  output logic       Mem_write,
  output logic       PC_write,
  output logic       old_PC_write,
  output logic       Adr_src,
  output logic       IR_write,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] w_alu_op;
  logic       w_unused;

  assign w_unused = ^{func7[6], func7[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FETCH;
    else      r_state <= w_next_state;
  end

  alu_decoder u_alu_decoder (
    .i_alu_op   (w_alu_op),
    .i_opc_b5   (opc[5]),
    .i_func3    (func3),
    .i_func7_b5 (func7[5]),
    .o_alu_cntr (ALU_cntr)
  );

  always_comb begin
    w_next_state = r_state;
    Reg_write    = 1'b0;
    Imm_src      = c_IMM_I;
    ALU_srcA     = c_SRCA_PC;
    ALU_srcB     = c_SRCB_REG;
    w_alu_op     = c_ALUOP_ADD;
    Result_src   = c_RES_ALUOUT;
    Mem_write    = 1'b0;
    PC_write     = 1'b0;
    old_PC_write = 1'b0;
    Adr_src      = 1'b0;
    IR_write     = 1'b0;
    illegal      = 1'b0;

    case (r_state)
      FETCH: begin
        IR_write     = 1'b1;
        old_PC_write = 1'b1;
        ALU_srcB     = c_SRCB_FOUR;
        Result_src   = c_RES_ALU;
        PC_write     = 1'b1;
        w_next_state = DECODE;
      end
      DECODE: begin
        // ALUOut captures oldPC + imm as the branch/jal target
        ALU_srcA = c_SRCA_OLDPC;
        ALU_srcB = c_SRCB_IMM;
        if (opc == c_OPC_BRANCH)   Imm_src = c_IMM_B;
        else if (opc == c_OPC_JAL) Imm_src = c_IMM_J;
        case (opc)
          c_OPC_R:      w_next_state = EXEC_R;
          c_OPC_I:      w_next_state = EXEC_I;
          c_OPC_LW,
          c_OPC_SW:     w_next_state = MEM_ADR;
          c_OPC_BRANCH: w_next_state = BRANCH;
          c_OPC_JAL:    w_next_state = JAL_LINK;
          c_OPC_JALR:   w_next_state = JALR_LINK;
          c_OPC_LUI:    w_next_state = LUI;
`ifdef ILLEGAL_TRAP_EN
          default:      w_next_state = HALT;
`else
          default:      w_next_state = FETCH;
`endif
        endcase
      end
      EXEC_R: begin
        ALU_srcA     = c_SRCA_REG;
        w_alu_op     = c_ALUOP_FUNCT;
        w_next_state = ALU_WB;
      end
      EXEC_I: begin
        ALU_srcA     = c_SRCA_REG;
        ALU_srcB     = c_SRCB_IMM;
        w_alu_op     = c_ALUOP_FUNCT;
        w_next_state = ALU_WB;
      end
      ALU_WB: begin
        Reg_write    = 1'b1;
        w_next_state = FETCH;
      end
      MEM_ADR, MEM_READ, MEM_WRITE: begin
        ALU_srcA = c_SRCA_REG;
        ALU_srcB = c_SRCB_IMM;
        Imm_src  = (opc == c_OPC_SW) ? c_IMM_S : c_IMM_I;
        if (r_state == MEM_ADR) begin
          w_next_state = (opc == c_OPC_SW) ? MEM_WRITE : MEM_READ;
        end else begin
          Adr_src      = 1'b1;
          Mem_write    = (r_state == MEM_WRITE);
          w_next_state = (r_state == MEM_WRITE) ? FETCH : MEM_WB;
        end
      end
      MEM_WB: begin
        Result_src   = c_RES_MDR;
        Reg_write    = 1'b1;
        w_next_state = FETCH;
      end
      BRANCH: begin
        ALU_srcA = c_SRCA_REG;
        w_alu_op = c_ALUOP_SUB;
        case (func3)
          3'b000:  PC_write = zero;
          3'b001:  PC_write = !zero;
          3'b100:  PC_write = !zero && !pos;
          3'b101:  PC_write = zero || pos;
          default: PC_write = 1'b0;
        endcase
        w_next_state = FETCH;
      end
      JAL_LINK: begin
        Result_src   = c_RES_PC;
        Reg_write    = 1'b1;
        ALU_srcA     = c_SRCA_OLDPC;
        ALU_srcB     = c_SRCB_IMM;
        Imm_src      = c_IMM_J;
        w_next_state = JAL_JUMP;
      end
      JALR_LINK: begin
        Result_src   = c_RES_PC;
        Reg_write    = 1'b1;
        ALU_srcA     = c_SRCA_REG;
        ALU_srcB     = c_SRCB_IMM;
        w_next_state = JALR_JUMP;
      end
      JAL_JUMP, JALR_JUMP: begin
        PC_write     = 1'b1;
        w_next_state = FETCH;
      end
      LUI: begin
        Imm_src      = c_IMM_U;
        Result_src   = c_RES_IMM;
        Reg_write    = 1'b1;
        w_next_state = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      HALT: begin
        illegal      = 1'b1;
        w_next_state = HALT;
      end
`endif
      default: w_next_state = FETCH;
    endcase

    // Reset overrides everything so an aborted instruction writes nothing
    if (!rst) begin
      Reg_write    = 1'b0;
      Imm_src      = c_IMM_I;
      ALU_srcA     = c_SRCA_PC;
      ALU_srcB     = c_SRCB_REG;
      w_alu_op     = c_ALUOP_ADD;
      Result_src   = c_RES_ALUOUT;
      Mem_write    = 1'b0;
      PC_write     = 1'b0;
      old_PC_write = 1'b0;
      Adr_src      = 1'b0;
      IR_write     = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed self-checking bench for multicycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opc = 7'b0;
  logic [2:0] func3 = 3'b0;
  logic [6:0] func7 = 7'b0;
  logic       zero = 1'b0;
  logic       pos = 1'b0;
  logic       Reg_write, Mem_write, PC_write, old_PC_write, Adr_src, IR_write, illegal;
  logic [2:0] Imm_src, ALU_cntr, Result_src;
  logic [1:0] ALU_srcA, ALU_srcB;

  int n_vec = 0;
  int n_err = 0;

  multicycle_controller dut (
    .clk          (clk),
    .rst          (rst),
    .opc          (opc),
    .func3        (func3),
    .func7        (func7),
    .zero         (zero),
    .pos          (pos),
    .Reg_write    (Reg_write),
    .Imm_src      (Imm_src),
    .ALU_srcA     (ALU_srcA),
    .ALU_srcB     (ALU_srcB),
    .ALU_cntr     (ALU_cntr),
    .Result_src   (Result_src),
    .Mem_write    (Mem_write),
    .PC_write     (PC_write),
    .old_PC_write (old_PC_write),
    .Adr_src      (Adr_src),
    .IR_write     (IR_write),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  logic [19:0] w_outs;
  assign w_outs = {Reg_write, Imm_src, ALU_srcA, ALU_srcB, ALU_cntr, Result_src,
                   Mem_write, PC_write, old_PC_write, Adr_src, IR_write, illegal};

  // Field order: rw imm sa sb cntr res mw pw opw as irw ill
  function automatic logic [19:0] pk(input logic rw, input logic [2:0] imm,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] cn, input logic [2:0] rs,
                                     input logic mw, input logic pw, input logic opw,
                                     input logic as, input logic irw, input logic ill);
    return {rw, imm, sa, sb, cn, rs, mw, pw, opw, as, irw, ill};
  endfunction

  task automatic chk(input string tag, input logic [19:0] exp);
    n_vec++;
    assert (w_outs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %05h expected %05h", tag, w_outs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [19:0] exp);
    @(negedge clk);
    chk(tag, exp);
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    opc   = o;
    func3 = f3;
    func7 = f7;
  endtask

  localparam logic [19:0] E_ZERO   = 20'h0;
  logic [19:0] e_fetch, e_wb;

  initial begin
    e_fetch = pk(0, 3'd0, 2'd0, 2'd2, 3'd0, 3'd1, 0, 1, 1, 0, 1, 0);
    e_wb    = pk(1, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0);

    // Reset
    #2 rst = 1'b0;
    #1 chk("reset_zero", E_ZERO);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("reset_fetch", e_fetch);

    // R-type sub
    set_ir(7'b0110011, 3'b000, 7'b0100000);
    step("r_decode", pk(0, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("r_exec_sub", pk(0, 3'd0, 2'd2, 2'd0, 3'd1, 3'd0, 0, 0, 0, 0, 0, 0));
    step("r_wb", e_wb);
    step("r_fetch", e_fetch);

    // R-type or
    set_ir(7'b0110011, 3'b110, 7'b0000000);
    step("or_decode", pk(0, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("or_exec", pk(0, 3'd0, 2'd2, 2'd0, 3'd3, 3'd0, 0, 0, 0, 0, 0, 0));
    step("or_wb", e_wb);
    step("or_fetch", e_fetch);

    // addi with func7[5]=1 must still add
    set_ir(7'b0010011, 3'b000, 7'b0100000);
    step("addi_decode", pk(0, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("addi_exec", pk(0, 3'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("addi_wb", e_wb);
    step("addi_fetch", e_fetch);

    // I-type sltiu
    set_ir(7'b0010011, 3'b011, 7'b0000000);
    step("sltiu_decode", pk(0, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("sltiu_exec", pk(0, 3'd0, 2'd2, 2'd1, 3'd6, 3'd0, 0, 0, 0, 0, 0, 0));
    step("sltiu_wb", e_wb);
    step("sltiu_fetch", e_fetch);

    // lw
    set_ir(7'b0000011, 3'b010, 7'b0000000);
    step("lw_decode", pk(0, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("lw_memadr", pk(0, 3'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("lw_memread", pk(0, 3'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0));
    step("lw_memwb", pk(1, 3'd0, 2'd0, 2'd0, 3'd0, 3'd2, 0, 0, 0, 0, 0, 0));
    step("lw_fetch", e_fetch);

    // sw
    set_ir(7'b0100011, 3'b010, 7'b0000000);
    step("sw_decode", pk(0, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("sw_memadr", pk(0, 3'd1, 2'd2, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("sw_memwrite", pk(0, 3'd1, 2'd2, 2'd1, 3'd0, 3'd0, 1, 0, 0, 1, 0, 0));
    step("sw_fetch", e_fetch);

    // bne, zero=1: not taken
    set_ir(7'b1100011, 3'b001, 7'b0000000);
    zero = 1'b1; pos = 1'b0;
    step("bne_decode", pk(0, 3'd2, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("bne_branch", pk(0, 3'd0, 2'd2, 2'd0, 3'd1, 3'd0, 0, 0, 0, 0, 0, 0));
    step("bne_fetch", e_fetch);

    // blt, zero=0 pos=0: taken
    set_ir(7'b1100011, 3'b100, 7'b0000000);
    zero = 1'b0; pos = 1'b0;
    step("blt_decode", pk(0, 3'd2, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("blt_branch", pk(0, 3'd0, 2'd2, 2'd0, 3'd1, 3'd0, 0, 1, 0, 0, 0, 0));
    step("blt_fetch", e_fetch);

    // bge, zero=1: taken
    set_ir(7'b1100011, 3'b101, 7'b0000000);
    zero = 1'b1; pos = 1'b0;
    step("bge_decode", pk(0, 3'd2, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("bge_branch", pk(0, 3'd0, 2'd2, 2'd0, 3'd1, 3'd0, 0, 1, 0, 0, 0, 0));
    step("bge_fetch", e_fetch);

    // beq, zero=0 pos=1: not taken; then unsupported func3 010 with zero=1
    set_ir(7'b1100011, 3'b000, 7'b0000000);
    zero = 1'b0; pos = 1'b1;
    step("beq_decode", pk(0, 3'd2, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("beq_branch", pk(0, 3'd0, 2'd2, 2'd0, 3'd1, 3'd0, 0, 0, 0, 0, 0, 0));
    step("beq_fetch", e_fetch);
    set_ir(7'b1100011, 3'b010, 7'b0000000);
    zero = 1'b1; pos = 1'b1;
    step("bxx_decode", pk(0, 3'd2, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("bxx_branch", pk(0, 3'd0, 2'd2, 2'd0, 3'd1, 3'd0, 0, 0, 0, 0, 0, 0));
    step("bxx_fetch", e_fetch);
    zero = 1'b0; pos = 1'b0;

    // jal
    set_ir(7'b1101111, 3'b000, 7'b0000000);
    step("jal_decode", pk(0, 3'd3, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("jal_link", pk(1, 3'd3, 2'd1, 2'd1, 3'd0, 3'd4, 0, 0, 0, 0, 0, 0));
    step("jal_jump", pk(0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0, 1, 0, 0, 0, 0));
    step("jal_fetch", e_fetch);

    // jalr
    set_ir(7'b1100111, 3'b000, 7'b0000000);
    step("jalr_decode", pk(0, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("jalr_link", pk(1, 3'd0, 2'd2, 2'd1, 3'd0, 3'd4, 0, 0, 0, 0, 0, 0));
    step("jalr_jump", pk(0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0, 1, 0, 0, 0, 0));
    step("jalr_fetch", e_fetch);

    // lui
    set_ir(7'b0110111, 3'b000, 7'b0000000);
    step("lui_decode", pk(0, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    step("lui_wb", pk(1, 3'd4, 2'd0, 2'd0, 3'd0, 3'd3, 0, 0, 0, 0, 0, 0));
    step("lui_fetch", e_fetch);

    // Reset asserted mid-DECODE
    set_ir(7'b0110011, 3'b000, 7'b0100000);
    step("mid_decode", pk(0, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
    #1 rst = 1'b0;
    #1 chk("mid_reset_zero", E_ZERO);
    step("mid_reset_hold", E_ZERO);
    rst = 1'b1;
    #1 chk("mid_reset_fetch", e_fetch);

    // Unknown opcode
    set_ir(7'b1111111, 3'b000, 7'b0000000);
    step("ill_decode", pk(0, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
`ifdef ILLEGAL_TRAP_EN
    step("ill_halt", pk(0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1));
    step("ill_halt_hold", pk(0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1));
    step("ill_halt_hold2", pk(0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1));
    rst = 1'b0;
    #1 chk("ill_reset_zero", E_ZERO);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("ill_reset_fetch", e_fetch);
`else
    step("ill_nop_fetch", e_fetch);
    set_ir(7'b0110111, 3'b000, 7'b0000000);
    step("ill_next_decode", pk(0, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
